serial_tx_param: RTL and testbench

Parametrised parallel-to-serial transmitter, the successor to the fixed 10-bit serial transmitter. Accepts words over a valid/ready handshake into a one-word holding buffer and shifts them out one bit per `i_tick` strobe, with configurable width, bit order and idle line level. Frames go out back-to-back with no gap bit when the buffer is refilled in time. It sits between the word-level data source and the serial output pin/channel.

---
 rtl/serial_tx_param.sv | 139 +++++++++++++
 tb/tb_serial_tx_param.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx_param.sv
// Parametrised parallel-to-serial transmitter with a one-word holding buffer and gapless framing.
// Optional even-parity bit after each frame when SERIAL_TX_PARITY_EN is defined.
module serial_tx_param #(
   parameter int unsigned DATA_W     = 10,
   parameter bit          MSB_FIRST  = 1'b0,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tick,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              s_data,
   output logic              o_busy,
   output logic              o_done
);

   localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

   // Bit that leaves the shifter next, depending on bit order.
   function automatic logic first_bit_f(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? w[DATA_W-1] : w[0];
   endfunction

   // Shifter advance with zero fill.
   function automatic logic [DATA_W-1:0] advance_f(input logic [DATA_W-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

`ifdef SERIAL_TX_PARITY_EN
   // Even parity: XOR of all data bits.
   function automatic logic parity_f(input logic [DATA_W-1:0] w);
      return ^w;
   endfunction

   logic              parity_r;
`endif

   state_t            state_r;
   logic [DATA_W-1:0] buf_r;
   logic              buf_full_r;
   logic              ready_r;
   logic [DATA_W-1:0] shift_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              s_data_r;
   logic              busy_r;
   logic              done_r;
   logic              end_frame_s;
   logic              load_s;

   // Frame-end and shifter-load decisions for the current tick.
   always_comb begin
      end_frame_s = 1'b0;
      load_s      = 1'b0;
      if (i_tick) begin
         case (state_r)
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: end_frame_s = 1'b1;
`else
            ST_SHIFT:  end_frame_s = (cnt_r == CNT_LAST);
`endif
            default:   end_frame_s = 1'b0;
         endcase
      end else begin
         end_frame_s = 1'b0;
      end
      load_s = i_tick && buf_full_r && ((state_r == ST_IDLE) || end_frame_s);
   end

   // Holding buffer, line FSM and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= ST_IDLE;
         buf_r      <= {DATA_W{1'b0}};
         buf_full_r <= 1'b0;
         ready_r    <= 1'b1;
         shift_r    <= {DATA_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         s_data_r   <= IDLE_LEVEL;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         parity_r   <= 1'b0;
`endif
      end else begin
         done_r <= end_frame_s;
         if (i_valid && ready_r) begin
            buf_r      <= i_data;
            buf_full_r <= 1'b1;
            ready_r    <= 1'b0;
         end
         // A load needs a full buffer, so it never collides with an accept.
         if (load_s) begin
            shift_r    <= advance_f(buf_r);
            s_data_r   <= first_bit_f(buf_r);
            cnt_r      <= CNT_ONE;
            state_r    <= ST_SHIFT;
            busy_r     <= 1'b1;
            buf_full_r <= 1'b0;
            ready_r    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_r   <= parity_f(buf_r);
`endif
         end else if (end_frame_s) begin
            s_data_r <= IDLE_LEVEL;
            cnt_r    <= {CNT_W{1'b0}};
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
         end else if (i_tick && (state_r == ST_SHIFT)) begin
            if (cnt_r != CNT_LAST) begin
               s_data_r <= first_bit_f(shift_r);
               shift_r  <= advance_f(shift_r);
               cnt_r    <= cnt_r + CNT_ONE;
            end
`ifdef SERIAL_TX_PARITY_EN
            else begin
               state_r  <= ST_PARITY;
               s_data_r <= parity_r;
            end
`endif
         end
      end
   end

   assign o_ready = ready_r;
   assign s_data  = s_data_r;
   assign o_busy  = busy_r;
   assign o_done  = done_r;

endmodule

// File: tb/tb_serial_tx_param.sv
// Bench for serial_tx_param: an LSB-first/idle-0 instance and an MSB-first/idle-1 instance
// driven identically and checked cycle by cycle against a stream-level reference model.
module tb_serial_tx_param;

   localparam int W = 10;
`ifdef SERIAL_TX_PARITY_EN
   localparam int F = W + 1;
`else
   localparam int F = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic         valid = 1'b0;
   logic [W-1:0] data = '0;
   logic         a_ready, a_sdata, a_busy, a_done;
   logic         b_ready, b_sdata, b_busy, b_done;

   int checks = 0;
   int failures = 0;
   int cur_k = 0;
   logic [W-1:0] words [0:3];

   serial_tx_param #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_valid(valid), .i_data(data),
      .o_ready(a_ready), .s_data(a_sdata), .o_busy(a_busy), .o_done(a_done));

   serial_tx_param #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_valid(valid), .i_data(data),
      .o_ready(b_ready), .s_data(b_sdata), .o_busy(b_busy), .o_done(b_done));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, obs, exp);
      end
   endtask

   // Expected line bit at position f of a frame carrying word w.
   function automatic logic exp_bit(input logic [W-1:0] w, input int f, input bit msb);
      if (f >= W) return ^w;
      return msb ? w[W-1-f] : w[f];
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_a_sdata"}, a_sdata, 1'b0);
      chk({tag, "_b_sdata"}, b_sdata, 1'b1);
      chk({tag, "_ready"}, {a_ready, b_ready}, 2'b11);
      chk({tag, "_busy"}, {a_busy, b_busy}, 2'b00);
      chk({tag, "_done"}, {a_done, b_done}, 2'b00);
   endtask

   // Streams n words from words[], ticking every `period` cycles; abort_k>=0 resets after that edge.
   task automatic run_stream(input int n, input int period, input int abort_k);
      int acc [0:3];
      int ld  [0:3];
      int k_end;
      for (int i = 0; i < n; i++) begin
         ld[i]  = (i * F + 1) * period;
         acc[i] = (i == 0) ? 0 : ld[i-1] + 1;
      end
      k_end = (n * F + 1) * period + 2;
      for (int k = 0; k <= k_end; k++) begin
         int m;
         int idx;
         bit rdy_low_before;
         bit rdy_low_after;
         bit exp_busy;
         bit exp_done;
         logic ea;
         logic eb;
         // inputs for edge k
         tick = (k % period) == 0;
         rdy_low_before = 1'b0;
         rdy_low_after  = 1'b0;
         idx = -1;
         for (int i = 0; i < n; i++) begin
            if (acc[i] == k) idx = i;
            if ((k > acc[i]) && (k <= ld[i])) rdy_low_before = 1'b1;
            if ((k >= acc[i]) && (k < ld[i])) rdy_low_after = 1'b1;
         end
         if (idx >= 0) begin
            valid = 1'b1;
            data  = words[idx];
         end else if (rdy_low_before) begin
            valid = 1'b1;
            data  = W'($urandom);
         end else begin
            valid = 1'b0;
            data  = W'($urandom);
         end
         @(negedge clk);
         cur_k = k;
         m = k / period;
         exp_busy = (m >= 1) && (m <= n * F);
         exp_done = ((k % period) == 0) && (m >= F + 1) && (((m - 1) % F) == 0) && (((m - 1) / F) <= n);
         if (exp_busy) begin
            ea = exp_bit(words[(m - 1) / F], (m - 1) % F, 1'b0);
            eb = exp_bit(words[(m - 1) / F], (m - 1) % F, 1'b1);
         end else begin
            ea = 1'b0;
            eb = 1'b1;
         end
         chk("a_sdata", a_sdata, ea);
         chk("b_sdata", b_sdata, eb);
         chk("ready", {a_ready, b_ready}, {2{~rdy_low_after}});
         chk("busy", {a_busy, b_busy}, {2{exp_busy}});
         chk("done", {a_done, b_done}, {2{exp_done}});
         if (k == abort_k) begin
            #1 rst_n = 1'b0;
            #1 chk_idle("abort_async");
            valid = 1'b0;
            tick  = 1'b1;
            @(negedge clk);
            chk_idle("abort_held");
            rst_n = 1'b1;
            for (int j = 0; j < 2 * F; j++) begin
               @(negedge clk);
               cur_k = k + 2 + j;
               chk_idle("after_abort");
            end
            break;
         end
      end
      valid = 1'b0;
      tick  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");

      // fixed-pattern word, full-rate ticks
      words[0] = 10'h2A5;
      run_stream(1, 1, -1);

      // gapless back-to-back all-ones then all-zeros
      words[0] = 10'h3FF;
      words[1] = 10'h000;
      run_stream(2, 1, -1);

      // tick every 4th cycle
      words[0] = W'($urandom);
      words[1] = W'($urandom);
      run_stream(2, 4, -1);

      // random words, tick every 3rd cycle
      for (int i = 0; i < 3; i++) words[i] = W'($urandom);
      run_stream(3, 3, -1);

      // four random words at full rate
      for (int i = 0; i < 4; i++) words[i] = W'($urandom);
      run_stream(4, 1, -1);

      // reset mid-frame with the next word buffered
      words[0] = W'($urandom);
      words[1] = W'($urandom);
      run_stream(2, 1, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
